// File: rtl/lc3_mem_pkg.sv
// Shared types and encodings for the LC3 memory responder.
// Holds the channel FSM states, the core's mem_state codes and the wait-counter width.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } chan_state_t;

    localparam logic [1:0] MS_RD   = 2'd0;
    localparam logic [1:0] MS_RDI  = 2'd1;
    localparam logic [1:0] MS_WR   = 2'd2;
    localparam logic [1:0] MS_IDLE = 2'd3;

    localparam int CNT_W = 4;

endpackage

// File: rtl/lc3_mem_chan.sv
// One request channel: IDLE -> WAIT -> DONE sequencer with a LAT-cycle wait counter.
// sample marks the edge a request is accepted; done marks the edge that enters DONE.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic sample,
    output logic done
);

    chan_state_t            state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (req) begin
                    sample     = 1'b1;
                    cnt_next   = CNT_W'(LAT);
                    state_next = (LAT == 0) ? DONE : WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        done = (state_next == DONE);
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side model for the LC3 core: independent instruction and data channels with
// configurable wait states over one shared word array, plus a backdoor preload port.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int INSTR_LAT = 0,
    parameter int DATA_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        Data_rd,
    input  logic [1:0]  mem_state,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] Instr_dout,
    output logic [15:0] Data_dout,
    output logic        complete_instr,
    output logic        complete_data
);

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    logic              instr_sample, instr_done;
    logic              data_sample, data_done;
    logic [ADDR_W-1:0] instr_addr_q, data_addr_q;
    logic [15:0]       data_din_q;
    logic              data_wr_q;

    logic              data_req;
    logic [ADDR_W-1:0] instr_addr, data_addr;
    logic [15:0]       data_din;
    logic              data_wr;

    assign data_req = (mem_state != MS_IDLE);

    lc3_mem_chan #(.LAT(INSTR_LAT)) u_instr_chan (
        .clk    (clk),
        .reset  (reset),
        .req    (instrmem_rd),
        .sample (instr_sample),
        .done   (instr_done)
    );

    lc3_mem_chan #(.LAT(DATA_LAT)) u_data_chan (
        .clk    (clk),
        .reset  (reset),
        .req    (data_req),
        .sample (data_sample),
        .done   (data_done)
    );

    // With zero wait states the sample and completion share an edge, so bypass the latches.
    assign instr_addr = instr_sample ? pc[ADDR_W-1:0]        : instr_addr_q;
    assign data_addr  = data_sample  ? Data_addr[ADDR_W-1:0] : data_addr_q;
    assign data_din   = data_sample  ? Data_din              : data_din_q;
    assign data_wr    = data_sample  ? (mem_state == MS_WR && !Data_rd) : data_wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_addr_q   <= '0;
            data_addr_q    <= '0;
            data_din_q     <= '0;
            data_wr_q      <= 1'b0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            Instr_dout     <= 16'h0000;
            Data_dout      <= 16'h0000;
        end else begin
            if (instr_sample) instr_addr_q <= instr_addr;
            if (data_sample) begin
                data_addr_q <= data_addr;
                data_din_q  <= data_din;
                data_wr_q   <= data_wr;
            end
            complete_instr <= instr_done;
            complete_data  <= data_done;
            if (instr_done)             Instr_dout <= mem[instr_addr];
            if (data_done && !data_wr)  Data_dout  <= mem[data_addr];
        end
    end

    // NOTE: the array is deliberately not reset; contents survive reset like real memory.
    // The commit is written last so it overrides a same-address backdoor load.
    always_ff @(posedge clk) begin
        if (load_en)              mem[load_addr[ADDR_W-1:0]] <= load_data;
        if (data_done && data_wr) mem[data_addr]             <= data_din;
    end

endmodule
